// File: rtl/player_pkg.sv
// Shared types and helpers for the player ship and its bullet pool.
package player_pkg;

   // One-hot ship states
   typedef enum logic [4:0] {
      ShipIdle  = 5'b00001,
      ShipMoveL = 5'b00010,
      ShipMoveR = 5'b00100,
      ShipHit   = 5'b01000,
      ShipDead  = 5'b10000
   } ship_state_e;

   typedef logic [9:0] coord_t;

   localparam int unsigned BulletW = 6;
   localparam int unsigned BulletH = 10;

   // Index of the lowest set bit of free_vec (0 when none is set; caller checks for any free)
   function automatic logic [2:0] first_free(input logic [7:0] free_vec);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (free_vec[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/player_multi_shot_if.sv
// Button, status and bullet-pool signals between the player block and its neighbours.
interface player_multi_shot_if #(
   parameter int unsigned bullets_p = 2
) ();
   logic                    frame_i;
   logic                    move_left_i;
   logic                    move_right_i;
   logic                    shoot_i;
   logic                    hit_i;
   logic [bullets_p-1:0]    hit_enemy_i;
   logic                    add_life_i;
   logic                    alive_o;
   logic                    frozen_o;
   logic [1:0]              lives_o;
   logic [4:0]              state_o;
   logic [9:0]              pos_left_o;
   logic [9:0]              pos_right_o;
   logic [11:0]             color_o;
   logic [bullets_p-1:0]    bullet_valid_o;
   logic [10*bullets_p-1:0] bullet_left_o;
   logic [10*bullets_p-1:0] bullet_top_o;

   // Button/collision side drives inputs and observes the ship
   modport master (
      output frame_i, move_left_i, move_right_i, shoot_i, hit_i, hit_enemy_i, add_life_i,
      input  alive_o, frozen_o, lives_o, state_o, pos_left_o, pos_right_o, color_o,
             bullet_valid_o, bullet_left_o, bullet_top_o
   );

   // The player block itself
   modport slave (
      input  frame_i, move_left_i, move_right_i, shoot_i, hit_i, hit_enemy_i, add_life_i,
      output alive_o, frozen_o, lives_o, state_o, pos_left_o, pos_right_o, color_o,
             bullet_valid_o, bullet_left_o, bullet_top_o
   );
endinterface

// File: rtl/player_bullet_slot.sv
// One player bullet: launched at a fixed column, climbs each frame, retires at the ceiling.
module player_bullet_slot
   import player_pkg::*;
#(
   parameter int unsigned spawn_top_p   = 424,
   parameter int unsigned bullet_step_p = 10,
   parameter int unsigned ceiling_p     = 10
) (
   input  logic   clk_i,
   input  logic   reset_ni,
   input  logic   launch_i,
   input  coord_t left_load_i,
   input  logic   frame_i,
   input  logic   retire_i,
   input  logic   clear_i,
   output logic   valid_o,
   output coord_t left_o,
   output coord_t top_o
);

   localparam coord_t SpawnTop  = coord_t'(spawn_top_p);
   localparam coord_t Step      = coord_t'(bullet_step_p);
   localparam coord_t RetireLim = coord_t'(ceiling_p + bullet_step_p);

   logic   valid_q, valid_d;
   coord_t left_q, left_d;
   coord_t top_q, top_d;

   // Next slot state: clear > launch > enemy-hit retire > frame motion
   always_comb begin
      valid_d = valid_q;
      left_d  = left_q;
      top_d   = top_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (launch_i) begin
         valid_d = 1'b1;
         left_d  = left_load_i;
         top_d   = SpawnTop;
      end else if (valid_q) begin
         if (retire_i) begin
            valid_d = 1'b0;
         end else if (frame_i) begin
            // Compare before subtracting so the top never wraps
            if (top_q < RetireLim) valid_d = 1'b0;
            else                   top_d   = top_q - Step;
         end
      end
   end

   // Slot registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         valid_q <= 1'b0;
         left_q  <= '0;
         top_q   <= SpawnTop;
      end else begin
         valid_q <= valid_d;
         left_q  <= left_d;
         top_q   <= top_d;
      end
   end

   assign valid_o = valid_q;
   assign left_o  = left_q;
   assign top_o   = top_q;

endmodule

// File: rtl/player_multi_shot.sv
// Player ship: move/hit/resume state machine, lives counter and a pool of bullet slots.
module player_multi_shot
   import player_pkg::*;
#(
   parameter logic [11:0] color_p       = 12'h5E5,
   parameter int unsigned bullets_p     = 2,
   parameter int unsigned lives_init_p  = 0,
   parameter int unsigned lives_max_p   = 3,
   parameter int unsigned ship_width_p  = 40,
   parameter int unsigned step_p        = 5,
   parameter int unsigned bullet_step_p = 10,
   parameter int unsigned left_border_p = 9,
   parameter int unsigned right_border_p = 629,
   parameter int unsigned reset_left_p  = 249,
   parameter int unsigned spawn_top_p   = 424,
   parameter int unsigned ceiling_p     = 10,
   parameter int unsigned cooldown_p    = 8
) (
   input logic                clk_i,
   input logic                reset_ni,
   player_multi_shot_if.slave bus
);

   localparam logic [4:0] StIdle  = ShipIdle;
   localparam logic [4:0] StMoveL = ShipMoveL;
   localparam logic [4:0] StMoveR = ShipMoveR;
   localparam logic [4:0] StHit   = ShipHit;
   localparam logic [4:0] StDead  = ShipDead;

   localparam int unsigned CdW = (cooldown_p > 0) ? $clog2(cooldown_p + 1) : 1;

   localparam coord_t     LeftMin   = coord_t'(left_border_p);
   localparam coord_t     LeftMax   = coord_t'(right_border_p - ship_width_p);
   localparam coord_t     Step      = coord_t'(step_p);
   localparam coord_t     ResetLeft = coord_t'(reset_left_p);
   localparam coord_t     MuzzleOff = coord_t'(ship_width_p / 2 - BulletW / 2);
   localparam logic [1:0] LivesInit = 2'(lives_init_p);
   localparam logic [1:0] LivesMax  = 2'(lives_max_p);

   logic [4:0]     state_q, state_d;
   coord_t         pos_left_q, pos_left_d;
   logic [1:0]     lives_q, lives_d;
   logic [CdW-1:0] cd_q, cd_d;
   logic           shoot_q;

   logic                 rise;
   logic                 alive_st;
   logic                 clear_all;
   logic                 launch_en;
   logic [7:0]           free_vec;
   logic [2:0]           free_idx;
   logic [bullets_p-1:0] valid;
   logic [bullets_p-1:0] launch_vec;
   coord_t               launch_left;
   coord_t               slot_left [bullets_p];
   coord_t               slot_top  [bullets_p];

   assign rise     = bus.shoot_i & ~shoot_q;
   assign alive_st = (state_q == StIdle) || (state_q == StMoveL) || (state_q == StMoveR);
   // Entering HIT/DEAD wipes the bullet pool and the cooldown
   assign clear_all = alive_st & bus.hit_i;

   // Launch decision and lowest-free-slot selection
   always_comb begin
      free_vec                = '0;
      free_vec[bullets_p-1:0] = ~valid;
      free_idx                = first_free(free_vec);
      launch_en   = rise && alive_st && !bus.hit_i && (cd_q == '0) && (|free_vec);
      launch_left = pos_left_q + MuzzleOff;
      for (int k = 0; k < bullets_p; k++) begin
         launch_vec[k] = launch_en && (free_idx == 3'(k));
      end
   end

   // Ship state, position and lives next-state
   always_comb begin
      state_d    = state_q;
      pos_left_d = pos_left_q;
      lives_d    = lives_q;
      case (state_q)
         StIdle, StMoveL, StMoveR: begin
            if (bus.frame_i && (state_q == StMoveL)) begin
               if (pos_left_q < LeftMin + Step) pos_left_d = LeftMin;
               else                            pos_left_d = pos_left_q - Step;
            end
            if (bus.frame_i && (state_q == StMoveR)) begin
               if (({1'b0, pos_left_q} + {1'b0, Step}) > {1'b0, LeftMax}) pos_left_d = LeftMax;
               else                                                       pos_left_d = pos_left_q + Step;
            end
            if (bus.hit_i) begin
               // Hit beats buttons and any same-cycle life bonus
               if (lives_q != 2'd0) begin
                  lives_d = lives_q - 2'd1;
                  state_d = StHit;
               end else begin
                  state_d = StDead;
               end
            end else begin
               if (bus.frame_i && bus.add_life_i && (lives_q < LivesMax)) lives_d = lives_q + 2'd1;
               if (bus.move_left_i && !bus.move_right_i)      state_d = StMoveL;
               else if (bus.move_right_i && !bus.move_left_i) state_d = StMoveR;
               else                                           state_d = StIdle;
            end
         end
         StHit: begin
            if (bus.frame_i && bus.add_life_i && (lives_q < LivesMax)) lives_d = lives_q + 2'd1;
            if (rise) begin
               pos_left_d = ResetLeft;
               state_d    = StIdle;
            end
         end
         StDead: begin
            if (rise) begin
               pos_left_d = ResetLeft;
               lives_d    = LivesInit;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Fire cooldown: load on launch, count down per frame, wiped on hit
   always_comb begin
      cd_d = cd_q;
      if (clear_all)                      cd_d = '0;
      else if (launch_en)                 cd_d = CdW'(cooldown_p);
      else if (bus.frame_i && cd_q != '0) cd_d = cd_q - 1'b1;
   end

   // Ship registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         pos_left_q <= ResetLeft;
         lives_q    <= LivesInit;
         cd_q       <= '0;
         shoot_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_left_q <= pos_left_d;
         lives_q    <= lives_d;
         cd_q       <= cd_d;
         shoot_q    <= bus.shoot_i;
      end
   end

   for (genvar k = 0; k < bullets_p; k++) begin : g_slot
      player_bullet_slot #(
         .spawn_top_p  (spawn_top_p),
         .bullet_step_p(bullet_step_p),
         .ceiling_p    (ceiling_p)
      ) u_slot (
         .clk_i      (clk_i),
         .reset_ni   (reset_ni),
         .launch_i   (launch_vec[k]),
         .left_load_i(launch_left),
         .frame_i    (bus.frame_i),
         .retire_i   (bus.hit_enemy_i[k]),
         .clear_i    (clear_all),
         .valid_o    (valid[k]),
         .left_o     (slot_left[k]),
         .top_o      (slot_top[k])
      );
   end

   // Pack per-slot coordinates onto the flat output buses
   always_comb begin
      bus.bullet_left_o = '0;
      bus.bullet_top_o  = '0;
      for (int k = 0; k < bullets_p; k++) begin
         bus.bullet_left_o[10*k +: 10] = slot_left[k];
         bus.bullet_top_o[10*k +: 10]  = slot_top[k];
      end
   end

   assign bus.bullet_valid_o = valid;
   assign bus.alive_o        = (state_q != StDead);
   assign bus.frozen_o       = (state_q == StHit) || (state_q == StDead);
   assign bus.lives_o        = lives_q;
   assign bus.state_o        = state_q;
   assign bus.pos_left_o     = pos_left_q;
   assign bus.pos_right_o    = pos_left_q + coord_t'(ship_width_p);
   assign bus.color_o        = color_p;

endmodule

// File: doc/player_multi_shot.md
Name: player_multi_shot

Overview:
Next-generation player ship block for the space-invaders playfield. It keeps the move/hit/resume ship state machine and adds a parametrised pool of independent player bullets with a per-frame fire cooldown. Lives, ship width, movement speed and playfield borders are parametrised. It sits between the debounced button inputs and the collision/VGA draw logic. All motion advances only on frame_i pulses.

Parameters:
color_p, 12'h5E5, ship colour {R,G,B}
bullets_p, 2, number of bullet slots (1..8)
lives_init_p, 0, extra lives loaded at reset and at new game
lives_max_p, 3, saturation value for the lives counter
ship_width_p, 40, ship width in pixels
step_p, 5, ship pixels moved per frame
bullet_step_p, 10, bullet pixels moved up per frame
left_border_p, 9, minimum pos_left
right_border_p, 629, maximum pos_right
reset_left_p, 249, pos_left after reset, resume or new game
spawn_top_p, 424, bullet top at launch
ceiling_p, 10, bullet retires when top < ceiling_p + bullet_step_p
cooldown_p, 8, frames between successive launches

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
frame_i  in  1  one-cycle pulse per video frame
move_left_i  in  1  left button
move_right_i  in  1  right button
shoot_i  in  1  fire / resume button (level)
hit_i  in  1  ship hit by enemy bullet
hit_enemy_i  in  bullets_p  per-slot enemy-hit retire request
add_life_i  in  1  level-beaten life bonus
alive_o  out  1  ship not in DEAD
frozen_o  out  1  state is HIT or DEAD
lives_o  out  2  current extra lives
state_o  out  5  one-hot ship state (debug)
pos_left_o / pos_right_o  out  10 each  ship edges; right = left + ship_width_p
color_o  out  12  color_p
bullet_valid_o  out  bullets_p  slot k in flight
bullet_left_o  out  10*bullets_p  slot k left at [10k+9:10k]; right = left+6 (computed by the consumer)
bullet_top_o  out  10*bullets_p  slot k top; bottom = top+10

Behaviour:
- Reset (async assert, sync release): state IDLE, pos_left = reset_left_p, lives = lives_init_p, all bullet_valid = 0, bullet tops = spawn_top_p, cooldown = 0, shoot edge register = 0. alive_o = 1, frozen_o = 0.
- Ship states (one-hot): IDLE, MOVE_L, MOVE_R, HIT, DEAD. The next state is registered every cycle.
  - Alive states (IDLE/MOVE_*): state follows the buttons. Exactly one button → MOVE_L or MOVE_R. Neither or both → IDLE.
  - On frame_i in MOVE_L: pos_left = max(pos_left − step_p, left_border_p). Saturate; never underflow.
  - On frame_i in MOVE_R: pos_left = min(pos_left + step_p, right_border_p − ship_width_p).
  - hit_i in an alive state has priority over the buttons. If lives > 0: lives−1 and go to HIT. If lives == 0: go to DEAD.
  - HIT: on a shoot rising edge, pos_left = reset_left_p and go to IDLE.
  - DEAD: on a shoot rising edge, pos_left = reset_left_p, lives = lives_init_p, and go to IDLE.
  - hit_i is ignored in HIT and DEAD.
  - Illegal or zero state encoding recovers to IDLE on the next cycle.
- Lives: add_life_i is sampled on frame_i and saturates at lives_max_p. If hit_i and add_life_i occur in the same cycle, hit wins and the add is dropped.
- Shoot edge: shoot_i is registered once. rise = shoot_i & ~shoot_q. Holding the button never auto-fires.
- Launch: on rise in an alive state with cooldown == 0 and at least one free slot:
  - The lowest-index free slot becomes valid with left = pos_left + ship_width_p/2 − 3 and top = spawn_top_p.
  - cooldown loads cooldown_p.
  - If no slot is free or cooldown ≠ 0, the request is dropped (not queued).
  - The launch is visible the cycle after rise.
- Cooldown decrements on frame_i and stops at 0.
- Flight: on frame_i each valid slot retires if top < ceiling_p + bullet_step_p; otherwise top −= bullet_step_p.
  - A slot's left is frozen from launch and does not track the ship.
- hit_enemy_i[k] retires slot k on the next edge. It beats the frame update and is ignored if slot k is not valid.
- A slot retired in cycle t is eligible for launch in cycle t+1, not in the same cycle.
- Entering HIT or DEAD clears all slots and the cooldown in the same edge.
- Width rule: all position arithmetic is 10-bit unsigned; clamping is done before any subtraction can wrap.

Decomposition:
- Package player_pkg:
  - ship_state_e enum (one-hot 5-bit)
  - coord_t (logic [9:0])
  - bullet width/height localparams (6, 10)
  - free-slot priority-encode function
- Sub-module player_bullet_slot: one per slot via generate. It holds valid, left and top, with inputs launch, left_load, frame, retire and clear.

Test Plan:
- Reset, then hold move_left_i for 50 frames → pos_left steps 244, 239, … reaches 9 on frame 48 and stays 9; state_o = MOVE_L throughout.
- From reset, single shoot pulse → next cycle bullet_valid_o = 01, slot0 left = 266, top = 424; after 41 frames top = 14; on frame 42 valid = 0.
- Two shoot pulses 3 frames apart → second dropped (cooldown); pulses 9 frames apart → slot1 launches; a third pulse with both slots busy is dropped.
- Slot0 in flight with hit_enemy_i = 01 coinciding with frame_i → valid clears next edge and top does not advance.
- lives = 1, hit_i → HIT, lives = 0, bullets cleared, frozen_o = 1; shoot rise → IDLE, pos_left = 249; hit_i again → DEAD, alive_o = 0; shoot rise → lives = lives_init_p.
- add_life_i for 5 frames → lives saturates at 3; hit_i and add_life_i in the same frame → lives decrements only; assert reset_ni mid-flight → all outputs return to reset values immediately.
